// File: rtl/sum_arbiter.sv
// sum_arbiter: two requesters share one 4-bit adder under round-robin arbitration.
// Latency: grant at the request edge; done is sampled high ADD_CYCLES+1 edges after the grant edge.
// Backpressure: requests arriving while busy get no grant and are arbitrated on the return to IDLE.
//
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   req0/req1           : operation requests from requester 0 / 1
//   a0,b0 / a1,b1       : 4-bit operands of requester 0 / 1, sampled on the grant edge
//   gnt0/gnt1           : requester currently owns the adder (one-hot or zero)
//   done0/done1         : one-cycle completion pulse for the owning requester
//   sum, carry          : registered (a+b) mod 16 and bit 4 of a+b, held until the next completion
//   busy                : high whenever the FSM is not IDLE
module sum_arbiter #(
   parameter int unsigned ADD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [3:0] a0,
   input  logic [3:0] b0,
   input  logic [3:0] a1,
   input  logic [3:0] b1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic [3:0] sum,
   output logic       carry,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(ADD_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] opa_q, opa_d;
   logic [3:0] opb_q, opb_d;
   logic       owner_q, owner_d;   // 0 = requester 0, 1 = requester 1
   logic       last_q, last_d;     // requester served most recently
   logic [3:0] sum_q, sum_d;
   logic       carry_q, carry_d;
   logic [4:0] add_res;
   logic       pick;

   // The adder only ever sees the latched operands, so input changes after
   // the grant edge cannot disturb an operation in flight.
   assign add_res = {1'b0, opa_q} + {1'b0, opb_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      owner_d = owner_q;
      last_d  = last_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      // On a tie the requester not served last wins; otherwise the lone requester.
      pick    = (req0 && req1) ? ~last_q : req1;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               owner_d = pick;
               opa_d   = pick ? a1 : a0;
               opb_d   = pick ? b1 : b0;
               cnt_d   = CNT_INIT;
               state_d = CALC;
            end
         end
         CALC: begin
            if (cnt_q == 4'd0) begin
               sum_d   = add_res[3:0];
               carry_d = add_res[4];
               last_d  = owner_q;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         opa_q   <= 4'd0;
         opb_q   <= 4'd0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         sum_q   <= 4'd0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   // Ownership lasts from the grant edge until the FSM leaves DONE.
   assign busy  = (state_q != IDLE);
   assign gnt0  = busy & ~owner_q;
   assign gnt1  = busy &  owner_q;
   assign done0 = (state_q == DONE) & ~owner_q;
   assign done1 = (state_q == DONE) &  owner_q;
   assign sum   = sum_q;
   assign carry = carry_q;

endmodule

// File: tb/tb_sum_arbiter.sv
module tb_sum_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0, req1;
   logic [3:0] a0, b0, a1, b1;

   // Index 0: ADD_CYCLES=2, index 1: ADD_CYCLES=1, index 2: ADD_CYCLES=15
   logic [2:0] g0, g1, dn0, dn1, cy, bz;
   logic [3:0] sm [3];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sum_arbiter #(.ADD_CYCLES(2)) u0 (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(g0[0]), .gnt1(g1[0]), .done0(dn0[0]), .done1(dn1[0]),
      .sum(sm[0]), .carry(cy[0]), .busy(bz[0]));

   sum_arbiter #(.ADD_CYCLES(1)) u1 (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(g0[1]), .gnt1(g1[1]), .done0(dn0[1]), .done1(dn1[1]),
      .sum(sm[1]), .carry(cy[1]), .busy(bz[1]));

   sum_arbiter #(.ADD_CYCLES(15)) u2 (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(g0[2]), .gnt1(g1[2]), .done0(dn0[2]), .done1(dn1[2]),
      .sum(sm[2]), .carry(cy[2]), .busy(bz[2]));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // ---------------- Behavioural model: timeline of transactions ----------------
   // Each operation is described by its grant edge t0 and its owner. The owner
   // holds the adder for edges t0..t0+ADD, done shows after edge t0+ADD, and the
   // unit is back in IDLE after edge t0+ADD+1.
   int         addc [3] = '{2, 1, 15};
   int         t = 0;
   bit         m_valid = 1'b0;
   bit         m_act  [3];
   int         m_t0   [3];
   bit         m_own  [3];
   bit         m_last [3];
   logic [3:0] m_sum  [3];
   bit         m_cy   [3];
   logic [4:0] m_pend [3];

   always @(posedge clk) begin
      t++;
      for (int k = 0; k < 3; k++) begin
         if (reset) begin
            m_act[k]  = 1'b0;
            m_last[k] = 1'b1;
            m_sum[k]  = 4'd0;
            m_cy[k]   = 1'b0;
         end else begin
            bit idle_before;
            idle_before = !m_act[k];
            if (m_act[k] && t == m_t0[k] + addc[k]) begin
               m_sum[k]  = m_pend[k][3:0];
               m_cy[k]   = m_pend[k][4];
               m_last[k] = m_own[k];
            end
            if (m_act[k] && t == m_t0[k] + addc[k] + 1)
               m_act[k] = 1'b0;
            if (idle_before && (req0 || req1)) begin
               m_own[k]  = (req0 && req1) ? !m_last[k] : req1;
               m_pend[k] = m_own[k] ? (5'(a1) + 5'(b1)) : (5'(a0) + 5'(b0));
               m_t0[k]   = t;
               m_act[k]  = 1'b1;
            end
         end
      end
      if (reset) m_valid = 1'b1;
   end

   // ---------------- Compare process ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         for (int k = 0; k < 3; k++) begin
            bit edone;
            edone = m_act[k] && (t == m_t0[k] + addc[k]);
            chk($sformatf("m_gnt0[%0d]", k),  g0[k],  m_act[k] && !m_own[k]);
            chk($sformatf("m_gnt1[%0d]", k),  g1[k],  m_act[k] &&  m_own[k]);
            chk($sformatf("m_done0[%0d]", k), dn0[k], edone && !m_own[k]);
            chk($sformatf("m_done1[%0d]", k), dn1[k], edone &&  m_own[k]);
            chk($sformatf("m_busy[%0d]", k),  bz[k],  m_act[k]);
            chk($sformatf("m_sum[%0d]", k),   sm[k],  m_sum[k]);
            chk($sformatf("m_carry[%0d]", k), cy[k],  m_cy[k]);
            chk($sformatf("gnt_excl[%0d]", k),  g0[k] & g1[k], 0);
            chk($sformatf("done_excl[%0d]", k), dn0[k] & dn1[k], 0);
         end
      end
   end

   // ---------------- Directed stimulus with literal expectations ----------------
   task automatic idle_wait(input int n);
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // One operation from an idle start; checks done latency per instance
   // (ADD+1 -> 3, 2, 16), the result, and that the other done never fires.
   task automatic run_op(input bit who, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] exp_s, input bit exp_c, input string tag);
      int first [3];
      int other_seen;
      first = '{-1, -1, -1};
      other_seen = 0;
      if (who) begin req1 = 1'b1; a1 = a; b1 = b; end
      else     begin req0 = 1'b1; a0 = a; b0 = b; end
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (n == 1) begin
            chk({tag, "_gnt_next"}, who ? g1[0] : g0[0], 1);
            req0 = 1'b0;
            req1 = 1'b0;
         end
         for (int k = 0; k < 3; k++) begin
            if ((who ? dn0[k] : dn1[k]) == 1'b1) other_seen++;
            if ((who ? dn1[k] : dn0[k]) == 1'b1 && first[k] < 0) begin
               first[k] = n;
               chk($sformatf("%s_sum[%0d]", tag, k), sm[k], exp_s);
               chk($sformatf("%s_carry[%0d]", tag, k), cy[k], exp_c);
            end
         end
         if (n == 4) chk({tag, "_pulse_len"}, who ? dn1[0] : dn0[0], 0);
      end
      chk({tag, "_lat_a2"},  first[0], 3);
      chk({tag, "_lat_a1"},  first[1], 2);
      chk({tag, "_lat_a15"}, first[2], 16);
      chk({tag, "_other_done"}, other_seen, 0);
   endtask

   initial begin
      int own [4];
      int when [4];
      int ng;
      bit prev;

      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_gnt0", g0[0], 0);
      chk("rst_busy", bz[0], 0);
      chk("rst_sum", sm[0], 0);
      chk("rst_carry", cy[0], 0);

      // Single op and overflow cases, both requesters, all three ADD_CYCLES
      run_op(1'b0, 4'd3,  4'd4, 4'd7, 1'b0, "op0_3p4");
      run_op(1'b1, 4'd15, 4'd1, 4'd0, 1'b1, "op1_15p1");
      run_op(1'b1, 4'd9,  4'd9, 4'd2, 1'b1, "op1_9p9");
      idle_wait(2);

      // Tie held after reset: grants alternate 0,1,0,1 four cycles apart
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      a0 = 4'd1; b0 = 4'd2; a1 = 4'd3; b1 = 4'd4;
      ng = 0;
      prev = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if ((g0[0] | g1[0]) && !prev && ng < 4) begin
            own[ng]  = g1[0];
            when[ng] = n;
            ng++;
         end
         prev = g0[0] | g1[0];
      end
      chk("tie_ngrants", ng, 4);
      if (ng == 4) begin
         chk("tie_own0", own[0], 0);
         chk("tie_own1", own[1], 1);
         chk("tie_own2", own[2], 0);
         chk("tie_own3", own[3], 1);
         chk("tie_first", when[0], 1);
         for (int i = 1; i < 4; i++)
            chk($sformatf("tie_gap%0d", i), when[i] - when[i-1], 4);
      end
      idle_wait(20);

      // Operand change after grant must be ignored: 5+2 stays 7
      req0 = 1'b1; a0 = 4'd5; b0 = 4'd2;
      @(negedge clk);
      a0 = 4'd12;
      req0 = 1'b0;
      begin
         bit seen;
         seen = 1'b0;
         for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (dn0[0]) begin
               seen = 1'b1;
               chk("stab_sum", sm[0], 7);
            end
         end
         chk("stab_done_seen", seen, 1);
      end
      idle_wait(20);

      // Reset one cycle into CALC: abort, everything zero, re-grant after release
      req0 = 1'b1; a0 = 4'd1; b0 = 4'd1;
      @(negedge clk);
      chk("rmid_gnt", g0[0], 1);
      reset = 1'b1;
      @(negedge clk);
      chk("rmid_gnt0", g0[0], 0);
      chk("rmid_done0", dn0[0], 0);
      chk("rmid_busy", bz[0], 0);
      chk("rmid_sum", sm[0], 0);
      chk("rmid_carry", cy[0], 0);
      reset = 1'b0;
      @(negedge clk);
      chk("rmid_regnt", g0[0], 1);
      idle_wait(20);

      // Randomised traffic checked against the model every cycle
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         req0  = $urandom_range(0, 1) == 1;
         req1  = $urandom_range(0, 1) == 1;
         a0 = 4'($urandom_range(0, 15));
         b0 = 4'($urandom_range(0, 15));
         a1 = 4'($urandom_range(0, 15));
         b1 = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      reset = 1'b0;
      idle_wait(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
